ami_req_arbiter: RTL and testbench
==================================

AMI_REQ_ARBITER -- requirements
Module: ami_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_APPS, default 4: number of requesting apps, legal range 1..16.
REQ-002 SHALL have parameter ADDR_W, default 64: memory byte-address width.
REQ-003 SHALL have parameter DATA_W, default 512: request and response data width.
REQ-004 SHALL have parameter RD_OUTSTANDING, default 8: maximum number of reads in flight, power of two, 2..64.
REQ-005 SHALL have port clk, input, 1: single clock for the whole block.
REQ-006 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port app_req_valid, input, NUM_APPS: per-app request valid.
REQ-008 SHALL have port app_req_is_write, input, NUM_APPS: 1 means write, 0 means read.
REQ-009 SHALL have port app_req_addr, input, NUM_APPS*ADDR_W: packed addresses; app i occupies slice [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port app_req_data, input, NUM_APPS*DATA_W: packed write data; ignored for reads.
REQ-011 SHALL have port app_req_ready, output, NUM_APPS: one-hot or zero grant/accept.
REQ-012 SHALL have ports mem_req_valid (output, 1), mem_req_is_write (output, 1), mem_req_addr (output, ADDR_W) and mem_req_data (output, DATA_W): the registered request slot toward the memory channel.
REQ-013 SHALL have port mem_req_ready, input, 1: memory channel accepts the request.
REQ-014 SHALL have ports mem_resp_valid (input, 1), mem_resp_data (input, DATA_W) and mem_resp_ready (output, 1): in-order read responses from memory.
REQ-015 SHALL have ports app_resp_valid (output, NUM_APPS) and app_resp_data (output, DATA_W, broadcast to all apps): read responses toward the apps.
REQ-016 SHALL have port app_resp_ready, input, NUM_APPS: per-app response accept.
REQ-017 SHALL have port err_unexpected_resp, output, 1: sticky flag set by a response arriving with no read outstanding.

Function
REQ-018 SHALL hold one registered request slot; slot_free = !mem_req_valid | mem_req_ready.
REQ-019 SHALL treat app i as eligible when app_req_valid[i]=1 and either is_write=1 or rd_count < RD_OUTSTANDING, with rd_count the registered value.
REQ-020 SHALL, when slot_free=1, grant the first eligible app in round-robin order, starting at (last_grant+1) mod NUM_APPS.
REQ-021 SHALL assert app_req_ready only for the granted app, in the same cycle combinationally; the handshake is app_req_valid & app_req_ready.
REQ-022 SHALL on a grant load the slot with the granted app's is_write, addr and data, set mem_req_valid on the next cycle, and update last_grant to the granted index.
REQ-023 SHALL keep last_grant unchanged when no grant occurs.
REQ-024 SHALL hold the slot contents stable while mem_req_valid=1 and mem_req_ready=0.
REQ-025 SHALL give a request latency of 1 cycle from app handshake to mem_req_valid, and sustain 1 request per cycle when mem_req_ready stays high.
REQ-026 SHALL, on each read grant, push the app index into an ID FIFO of depth RD_OUTSTANDING; rd_count is the FIFO occupancy.
REQ-027 SHALL push no ID for writes, since writes have no response.
REQ-028 SHALL, when the ID FIFO is non-empty, set app_resp_valid[head] = mem_resp_valid, with all other app_resp_valid bits at 0.
REQ-029 SHALL drive mem_resp_ready = app_resp_ready[head] whenever the ID FIFO is non-empty.
REQ-030 SHALL pass mem_resp_data combinationally to app_resp_data.
REQ-031 SHALL pop the ID FIFO on mem_resp_valid & mem_resp_ready.
REQ-032 SHALL allow a push and a pop in the same cycle, leaving rd_count unchanged, including at full.
REQ-033 SHALL keep reads ineligible at rd_count = RD_OUTSTANDING, even if a pop occurs that cycle; writes from the same app remain eligible.
REQ-034 SHALL, when mem_resp_valid=1 with the ID FIFO empty, drive mem_resp_ready=0 and all app_resp_valid=0, and set err_unexpected_resp; the flag is cleared only by rst.

Reset
REQ-035 SHALL on rst=1 at a clock edge set mem_req_valid=0, empty the ID FIFO (rd_count=0), set last_grant=NUM_APPS-1 so that app 0 has first priority, and clear err_unexpected_resp.
REQ-036 SHALL hold app_req_ready=0, app_resp_valid=0 and mem_resp_ready=0 while rst=1.
REQ-037 SHALL discard an in-flight slot and all outstanding IDs on reset mid-operation; late memory responses after reset then set err_unexpected_resp.

Verification
REQ-038 SHALL be covered by: apps 0-3 all issue valid reads, mem_req_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, and mem_req_addr follows 1 cycle after each grant.
REQ-039 SHALL be covered by: mem_req_ready=0 for 5 cycles with app 2 write at addr 0x40 -> slot holds 0x40 stable, app_req_ready=0 for all apps, and exactly one write is issued once ready=1.
REQ-040 SHALL be covered by: RD_OUTSTANDING=8, 8 reads issued with no responses -> app 1's 9th read is stalled while app 1's write is granted; after one response, the read is granted the following cycle.
REQ-041 SHALL be covered by: reads issued in the order app3, app0, app3, then 3 responses D0, D1, D2 -> delivered to apps 3, 0, 3; with app_resp_ready[0]=0, mem_resp_ready=0 until it rises.
REQ-042 SHALL be covered by: mem_resp_valid=1 right after reset -> err_unexpected_resp=1, which stays 1 until the next rst.
REQ-043 SHALL be covered by: rst asserted with 3 reads outstanding -> rd_count=0 and mem_req_valid=0 the next cycle, and app 0 wins the first post-reset grant.

Source files
------------

// File: rtl/ami_req_arbiter.sv
// Round-robin arbiter that funnels NUM_APPS request ports into one registered
// memory request slot and routes in-order read responses back to the app that
// issued each read, using a FIFO of app IDs.
//
// Handshakes: every channel transfers on a cycle where valid & ready are both 1.
// A valid is never withdrawn by this block while waiting for ready (the request
// slot holds its contents while mem_req_valid & !mem_req_ready), and ready
// may depend combinationally on valid (app_req_ready, mem_resp_ready).
module ami_req_arbiter #(
  parameter int NUM_APPS       = 4,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 512,
  parameter int RD_OUTSTANDING = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_APPS-1:0]        app_req_valid,
  input  logic [NUM_APPS-1:0]        app_req_is_write,
  input  logic [NUM_APPS*ADDR_W-1:0] app_req_addr,
  input  logic [NUM_APPS*DATA_W-1:0] app_req_data,
  output logic [NUM_APPS-1:0]        app_req_ready,
  output logic                       mem_req_valid,
  output logic                       mem_req_is_write,
  output logic [ADDR_W-1:0]          mem_req_addr,
  output logic [DATA_W-1:0]          mem_req_data,
  input  logic                       mem_req_ready,
  input  logic                       mem_resp_valid,
  input  logic [DATA_W-1:0]          mem_resp_data,
  output logic                       mem_resp_ready,
  output logic [NUM_APPS-1:0]        app_resp_valid,
  output logic [DATA_W-1:0]          app_resp_data,
  input  logic [NUM_APPS-1:0]        app_resp_ready,
  output logic                       err_unexpected_resp
);

  localparam int ID_W  = (NUM_APPS > 1) ? $clog2(NUM_APPS) : 1;
  localparam int PTR_W = $clog2(RD_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_APPS - 1);
  localparam logic [CNT_W-1:0] RD_MAX   = CNT_W'(RD_OUTSTANDING);

  logic                mem_req_valid_q, mem_req_valid_d;
  logic                slot_wr_q, slot_wr_d;
  logic [ADDR_W-1:0]   slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0]   slot_data_q, slot_data_d;
  logic [ID_W-1:0]     last_grant_q, last_grant_d;
  logic [CNT_W-1:0]    rd_count_q, rd_count_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ID_W-1:0]     id_mem_q [RD_OUTSTANDING];
  logic [ID_W-1:0]     id_mem_d [RD_OUTSTANDING];
  logic                err_q, err_d;

  logic                slot_free;
  logic                rd_ok;
  logic [NUM_APPS-1:0] eligible;
  logic                grant_valid;
  int                  grant_sel;
  logic [ID_W-1:0]     grant_idx;
  logic                fifo_empty;
  logic [ID_W-1:0]     head;
  logic                push, pop;

  // Round-robin pick of the first eligible app after last_grant; reads are
  // blocked on the registered occupancy so a same-cycle pop cannot unblock them.
  always_comb begin
    int cand;
    cand        = 0;
    slot_free   = !mem_req_valid_q || mem_req_ready;
    rd_ok       = (rd_count_q < RD_MAX);
    eligible    = app_req_valid & (app_req_is_write | {NUM_APPS{rd_ok}});
    grant_valid = 1'b0;
    grant_sel   = 0;
    for (int k = 0; k < NUM_APPS; k++) begin
      cand = (int'(last_grant_q) + 1 + k) % NUM_APPS;
      if (!grant_valid && eligible[cand]) begin
        grant_valid = 1'b1;
        grant_sel   = cand;
      end
    end
    if (rst || !slot_free) begin
      grant_valid = 1'b0;
    end
    grant_idx     = ID_W'(grant_sel);
    app_req_ready = '0;
    if (grant_valid) begin
      app_req_ready[grant_idx] = 1'b1;
    end
  end

  // Response routing: the FIFO head names the app that owns the next response.
  always_comb begin
    fifo_empty     = (rd_count_q == '0);
    head           = id_mem_q[rd_ptr_q];
    app_resp_valid = '0;
    mem_resp_ready = 1'b0;
    if (!rst && !fifo_empty) begin
      app_resp_valid[head] = mem_resp_valid;
      mem_resp_ready       = app_resp_ready[head];
    end
    app_resp_data = mem_resp_data;
    pop  = mem_resp_valid && mem_resp_ready;
    push = grant_valid && !app_req_is_write[grant_idx];
  end

  // Next-state for the request slot, grant pointer, ID FIFO and error flag.
  always_comb begin
    mem_req_valid_d = mem_req_valid_q;
    slot_wr_d       = slot_wr_q;
    slot_addr_d     = slot_addr_q;
    slot_data_d     = slot_data_q;
    last_grant_d    = last_grant_q;
    rd_count_d      = rd_count_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    id_mem_d        = id_mem_q;
    err_d           = err_q || (mem_resp_valid && fifo_empty);

    if (grant_valid) begin
      mem_req_valid_d = 1'b1;
      slot_wr_d       = app_req_is_write[grant_idx];
      last_grant_d    = grant_idx;
      for (int i = 0; i < NUM_APPS; i++) begin
        if (i == grant_sel) begin
          slot_addr_d = app_req_addr[i*ADDR_W +: ADDR_W];
          slot_data_d = app_req_data[i*DATA_W +: DATA_W];
        end
      end
    end else if (mem_req_ready) begin
      mem_req_valid_d = 1'b0;
    end

    if (push) begin
      id_mem_d[wr_ptr_q] = grant_idx;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   rd_count_d = rd_count_q + CNT_W'(1);
      2'b01:   rd_count_d = rd_count_q - CNT_W'(1);
      default: rd_count_d = rd_count_q;
    endcase
  end

  // Control state with synchronous reset; reset drops the slot and all IDs.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_valid_q <= 1'b0;
      slot_wr_q       <= 1'b0;
      slot_addr_q     <= '0;
      slot_data_q     <= '0;
      last_grant_q    <= LAST_RST;
      rd_count_q      <= '0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      mem_req_valid_q <= mem_req_valid_d;
      slot_wr_q       <= slot_wr_d;
      slot_addr_q     <= slot_addr_d;
      slot_data_q     <= slot_data_d;
      last_grant_q    <= last_grant_d;
      rd_count_q      <= rd_count_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      err_q           <= err_d;
    end
  end

  // ID storage needs no reset: entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    id_mem_q <= id_mem_d;
  end

  assign mem_req_valid       = mem_req_valid_q;
  assign mem_req_is_write    = slot_wr_q;
  assign mem_req_addr        = slot_addr_q;
  assign mem_req_data        = slot_data_q;
  assign err_unexpected_resp = err_q;

endmodule

// File: tb/tb_ami_req_arbiter.sv
// Bench for ami_req_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a queue-based reference model.
module tb_ami_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RD = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      app_req_valid, app_req_is_write, app_req_ready;
  logic [N*AW-1:0]   app_req_addr;
  logic [N*DW-1:0]   app_req_data;
  logic              mem_req_valid, mem_req_is_write, mem_req_ready;
  logic [AW-1:0]     mem_req_addr;
  logic [DW-1:0]     mem_req_data;
  logic              mem_resp_valid, mem_resp_ready;
  logic [DW-1:0]     mem_resp_data, app_resp_data;
  logic [N-1:0]      app_resp_valid, app_resp_ready;
  logic              err_unexpected_resp;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending read owners kept in issue order.
  logic [3:0]        exp_q[$];
  int                m_last = N - 1;
  bit                m_slot_v = 0;
  bit                m_slot_wr = 0;
  logic [AW-1:0]     m_slot_addr = '0;
  logic [DW-1:0]     m_slot_data = '0;
  bit                m_err = 0;

  ami_req_arbiter #(.NUM_APPS(N), .ADDR_W(AW), .DATA_W(DW), .RD_OUTSTANDING(RD)) dut (
    .clk(clk), .rst(rst),
    .app_req_valid(app_req_valid), .app_req_is_write(app_req_is_write),
    .app_req_addr(app_req_addr), .app_req_data(app_req_data),
    .app_req_ready(app_req_ready),
    .mem_req_valid(mem_req_valid), .mem_req_is_write(mem_req_is_write),
    .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .mem_resp_ready(mem_resp_ready),
    .app_resp_valid(app_resp_valid), .app_resp_data(app_resp_data),
    .app_resp_ready(app_resp_ready),
    .err_unexpected_resp(err_unexpected_resp)
  );

  // Clock
  initial forever #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver helpers
  task automatic set_app(input int i, input bit v, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    app_req_valid[i]          = v;
    app_req_is_write[i]       = wr;
    app_req_addr[i*AW +: AW]  = a;
    app_req_data[i*DW +: DW]  = d;
  endtask

  task automatic clear_inputs();
    app_req_valid    = '0;
    app_req_is_write = '0;
    app_req_addr     = '0;
    app_req_data     = '0;
    mem_req_ready    = 1'b1;
    mem_resp_valid   = 1'b0;
    mem_resp_data    = '0;
    app_resp_ready   = '1;
  endtask

  // One cycle: compare outputs at the falling edge, advance the model at the
  // rising edge, then return just after it so the caller can drive new inputs.
  task automatic step();
    int g;
    int c;
    int head;
    logic [N-1:0] e_ready, e_rvalid;
    logic e_mrr;
    @(negedge clk);
    g = -1;
    if (!rst && (!m_slot_v || mem_req_ready)) begin
      for (int k = 0; k < N; k++) begin
        c = (m_last + 1 + k) % N;
        if (g < 0 && app_req_valid[c] && (app_req_is_write[c] || exp_q.size() < RD)) g = c;
      end
    end
    e_ready = '0;
    if (g >= 0) e_ready[g] = 1'b1;
    e_rvalid = '0;
    e_mrr    = 1'b0;
    head     = 0;
    if (!rst && exp_q.size() > 0) begin
      head           = int'(exp_q[0]);
      e_rvalid[head] = mem_resp_valid;
      e_mrr          = app_resp_ready[head];
    end
    check("app_req_ready", app_req_ready, e_ready);
    check("mem_req_valid", mem_req_valid, m_slot_v);
    if (m_slot_v) begin
      check("mem_req_is_write", mem_req_is_write, m_slot_wr);
      check("mem_req_addr", mem_req_addr, m_slot_addr);
      check("mem_req_data", mem_req_data, m_slot_data);
    end
    check("app_resp_valid", app_resp_valid, e_rvalid);
    check("mem_resp_ready", mem_resp_ready, e_mrr);
    check("app_resp_data", app_resp_data, mem_resp_data);
    check("err_unexpected_resp", err_unexpected_resp, m_err);
    @(posedge clk);
    if (rst) begin
      m_slot_v = 0;
      exp_q.delete();
      m_last = N - 1;
      m_err = 0;
    end else begin
      if (mem_resp_valid && exp_q.size() == 0) m_err = 1;
      if (mem_resp_valid && e_mrr) void'(exp_q.pop_front());
      if (g >= 0) begin
        m_slot_v    = 1;
        m_slot_wr   = app_req_is_write[g];
        m_slot_addr = app_req_addr[g*AW +: AW];
        m_slot_data = app_req_data[g*DW +: DW];
        m_last      = g;
        if (!app_req_is_write[g]) exp_q.push_back(4'(g));
      end else if (mem_req_ready) begin
        m_slot_v = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Reset state
    step();
    step();
    rst = 1'b0;

    // Response with nothing outstanding sets a sticky error
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom;
    step();
    mem_resp_valid = 1'b0;
    repeat (3) step();
    do_reset();

    // All four apps read: grants rotate 0,1,2,3,0
    for (int i = 0; i < N; i++) set_app(i, 1, 0, 32'h100 + 32'(i * 8), $urandom);
    repeat (5) step();
    clear_inputs();
    step();
    do_reset();

    // Backpressure: write from app 2 held in the slot while ready is low
    set_app(2, 1, 1, 32'h40, $urandom);
    step();
    set_app(2, 1, 1, 32'h80, $urandom);
    mem_req_ready = 1'b0;
    repeat (5) step();
    set_app(2, 0, 0, '0, '0);
    mem_req_ready = 1'b1;
    repeat (2) step();
    do_reset();

    // Read limit: 8 reads fill the ID FIFO; app 1 read stalls, write passes
    set_app(0, 1, 0, 32'h1000, $urandom);
    repeat (RD) step();
    set_app(0, 0, 0, '0, '0);
    set_app(1, 1, 0, 32'h200, $urandom);
    repeat (2) step();
    set_app(1, 1, 1, 32'h300, $urandom);
    step();
    set_app(1, 1, 0, 32'h200, $urandom);
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom;
    step();
    mem_resp_valid = 1'b0;
    step();
    set_app(1, 0, 0, '0, '0);
    step();
    do_reset();

    // Routing: reads by apps 3,0,3 answered in order; app 0 holds off
    set_app(3, 1, 0, 32'h30, $urandom);
    step();
    set_app(3, 0, 0, '0, '0);
    set_app(0, 1, 0, 32'h00, $urandom);
    step();
    set_app(0, 0, 0, '0, '0);
    set_app(3, 1, 0, 32'h38, $urandom);
    step();
    set_app(3, 0, 0, '0, '0);
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'hD0D0_0000;
    step();
    mem_resp_data  = 32'hD1D1_1111;
    app_resp_ready = 4'b1110;
    repeat (2) step();
    app_resp_ready = 4'b1111;
    step();
    mem_resp_data  = 32'hD2D2_2222;
    step();
    mem_resp_valid = 1'b0;
    step();
    do_reset();

    // Reset mid-operation with reads outstanding, then a late response
    for (int i = 1; i < N; i++) set_app(i, 1, 0, 32'h500 + 32'(i), $urandom);
    repeat (3) step();
    clear_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_app(i, 1, 0, 32'h600 + 32'(i), $urandom);
    step();
    clear_inputs();
    step();
    mem_resp_valid = 1'b1;
    mem_resp_data  = $urandom;
    step();
    mem_resp_valid = 1'b0;
    step();
    do_reset();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int i = 0; i < N; i++)
        set_app(i, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom, $urandom);
      mem_req_ready  = ($urandom_range(0, 9) < 7);
      mem_resp_valid = ($urandom_range(0, 2) == 0);
      mem_resp_data  = $urandom;
      app_resp_ready = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b0;
    clear_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
